cpu64_l2_port_arbiter: RTL and testbench

//  Shares the single CPU-side OBI port of the L2 D$ between two L1 requesters (m0 = L1 I$, m1 = L1 D$).
//  - Round-robin arbitration with one outstanding transaction; responses routed to the owner only.
//  - Fans the L2->L1 back-invalidate out to both L1s and merges their acks into one ack to L2.
//  - Sits between the L1 caches and cpu64_l2_dcache.

---
 rtl/cpu64_l2_port_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_cpu64_l2_port_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu64_l2_port_arbiter.sv
// Two-requester arbiter for the L2 D$ CPU-side OBI port (m0 = L1 I$, m1 = L1 D$).
// Optional fixed priority (m1 always wins) via CPU64_L2_ARB_FIXED_PRIO_EN.
module cpu64_l2_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    // requester 0 (L1 I$)
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    // requester 1 (L1 D$)
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    // L2 CPU port
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_gnt_i,
    input  logic                s_rvalid_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    // back-invalidate from L2
    input  logic                s_inv_req_i,
    input  logic [ADDR_W-1:0]   s_inv_addr_i,
    output logic                s_inv_ack_o,
    // back-invalidate fan-out to L1s
    output logic                m0_inv_req_o,
    output logic [ADDR_W-1:0]   m0_inv_addr_o,
    input  logic                m0_inv_ack_i,
    output logic                m1_inv_req_o,
    output logic [ADDR_W-1:0]   m1_inv_addr_o,
    input  logic                m1_inv_ack_i
);

    typedef enum logic {
        A_IDLE,
        A_BUSY
    } arb_state_e;

    typedef enum logic [1:0] {
        I_IDLE,
        I_WAIT,
        I_DONE
    } inv_state_e;

    arb_state_e arb_q;
    inv_state_e inv_q;

    logic       owner_q;
    logic       own_we_q;
    logic       any_req;
    logic       win;
    logic       done;
    logic [1:0] seen_q;
    logic [1:0] seen_nx;

    assign any_req = m0_req_i | m1_req_i;

    // A transaction ends on gnt for writes, on rvalid for reads
    // (rvalid alone covers the L2 miss case where gnt never shows).
    assign done = own_we_q ? s_gnt_i : s_rvalid_i;

`ifdef CPU64_L2_ARB_FIXED_PRIO_EN
    // D$ wins whenever it asks; no rotation state exists in this build.
    always_comb begin
        win = m1_req_i;
    end
`else
    logic rr_q;

    // Preferred requester if it asks, otherwise the other one.
    always_comb begin
        win = rr_q ? m1_req_i : ~m0_req_i;
    end

    // Rotate preference away from the requester just served.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else if (arb_q == A_BUSY && done) begin
            rr_q <= ~owner_q;
        end
    end
`endif

    // Arbitration FSM: one outstanding transaction at a time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_q    <= A_IDLE;
            owner_q  <= 1'b0;
            own_we_q <= 1'b0;
        end else begin
            unique case (arb_q)
                A_IDLE: begin
                    if (any_req) begin
                        owner_q  <= win;
                        own_we_q <= win ? m1_we_i : m0_we_i;
                        arb_q    <= A_BUSY;
                    end
                end
                A_BUSY: begin
                    if (done) begin
                        arb_q <= A_IDLE;
                    end
                end
                default: arb_q <= A_IDLE;
            endcase
        end
    end

    // Route the owner's request to L2 and L2's handshake back to the owner.
    always_comb begin
        s_req_o     = 1'b0;
        s_we_o      = 1'b0;
        s_be_o      = '0;
        s_addr_o    = '0;
        s_wdata_o   = '0;
        m0_gnt_o    = 1'b0;
        m0_rvalid_o = 1'b0;
        m1_gnt_o    = 1'b0;
        m1_rvalid_o = 1'b0;
        if (arb_q == A_BUSY) begin
            if (owner_q) begin
                s_req_o     = m1_req_i;
                s_we_o      = m1_we_i;
                s_be_o      = m1_be_i;
                s_addr_o    = m1_addr_i;
                s_wdata_o   = m1_wdata_i;
                m1_gnt_o    = s_gnt_i;
                m1_rvalid_o = s_rvalid_i;
            end else begin
                s_req_o     = m0_req_i;
                s_we_o      = m0_we_i;
                s_be_o      = m0_be_i;
                s_addr_o    = m0_addr_i;
                s_wdata_o   = m0_wdata_i;
                m0_gnt_o    = s_gnt_i;
                m0_rvalid_o = s_rvalid_i;
            end
        end
    end

    assign m0_rdata_o = s_rdata_i;
    assign m1_rdata_o = s_rdata_i;

    // Acks collected so far including the ones arriving this cycle.
    always_comb begin
        seen_nx = seen_q | {m1_inv_ack_i, m0_inv_ack_i};
    end

    // Invalidate FSM: fan out, gather both acks, pulse one merged ack.
    // I_DONE waits out the lagging L2 request before re-arming.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inv_q       <= I_IDLE;
            seen_q      <= 2'b00;
            s_inv_ack_o <= 1'b0;
        end else begin
            s_inv_ack_o <= 1'b0;
            unique case (inv_q)
                I_IDLE: begin
                    if (s_inv_req_i) begin
                        seen_q <= 2'b00;
                        inv_q  <= I_WAIT;
                    end
                end
                I_WAIT: begin
                    seen_q <= seen_nx;
                    if (&seen_nx) begin
                        s_inv_ack_o <= 1'b1;
                        inv_q       <= I_DONE;
                    end
                end
                I_DONE: begin
                    if (!s_inv_req_i) begin
                        inv_q <= I_IDLE;
                    end
                end
                default: inv_q <= I_IDLE;
            endcase
        end
    end

    // An L1 stops seeing the request once it has acked.
    always_comb begin
        m0_inv_req_o = 1'b0;
        m1_inv_req_o = 1'b0;
        if (inv_q == I_WAIT) begin
            m0_inv_req_o = s_inv_req_i & ~seen_q[0];
            m1_inv_req_o = s_inv_req_i & ~seen_q[1];
        end
    end

    assign m0_inv_addr_o = s_inv_addr_i;
    assign m1_inv_addr_o = s_inv_addr_i;

endmodule

// File: tb/tb_cpu64_l2_port_arbiter.sv
// Bench for cpu64_l2_port_arbiter: directed literal checks plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_cpu64_l2_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;
`ifdef CPU64_L2_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;

    logic [1:0]         m_req;
    logic [1:0]         m_we;
    logic [1:0][BW-1:0] m_be;
    logic [1:0][AW-1:0] m_addr;
    logic [1:0][DW-1:0] m_wdata;
    logic [1:0]         m_inv_ack;
    wire  [1:0]         m_gnt;
    wire  [1:0]         m_rvalid;
    wire  [1:0][DW-1:0] m_rdata;
    wire  [1:0]         m_inv_req;
    wire  [1:0][AW-1:0] m_inv_addr;

    wire          s_req_o;
    wire          s_we_o;
    wire [BW-1:0] s_be_o;
    wire [AW-1:0] s_addr_o;
    wire [DW-1:0] s_wdata_o;
    wire          s_inv_ack_o;
    logic          s_gnt_i;
    logic          s_rvalid_i;
    logic [DW-1:0] s_rdata_i;
    logic          s_inv_req_i;
    logic [AW-1:0] s_inv_addr_i;

    cpu64_l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m0_req_i(m_req[0]), .m0_we_i(m_we[0]), .m0_be_i(m_be[0]),
        .m0_addr_i(m_addr[0]), .m0_wdata_i(m_wdata[0]),
        .m0_gnt_o(m_gnt[0]), .m0_rvalid_o(m_rvalid[0]), .m0_rdata_o(m_rdata[0]),
        .m1_req_i(m_req[1]), .m1_we_i(m_we[1]), .m1_be_i(m_be[1]),
        .m1_addr_i(m_addr[1]), .m1_wdata_i(m_wdata[1]),
        .m1_gnt_o(m_gnt[1]), .m1_rvalid_o(m_rvalid[1]), .m1_rdata_o(m_rdata[1]),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .s_inv_req_i(s_inv_req_i), .s_inv_addr_i(s_inv_addr_i),
        .s_inv_ack_o(s_inv_ack_o),
        .m0_inv_req_o(m_inv_req[0]), .m0_inv_addr_o(m_inv_addr[0]),
        .m0_inv_ack_i(m_inv_ack[0]),
        .m1_inv_req_o(m_inv_req[1]), .m1_inv_addr_o(m_inv_addr[1]),
        .m1_inv_ack_i(m_inv_ack[1])
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner = -1 when nobody holds the port; last = requester served last.
    int       owner;
    bit       own_we;
    int       last;
    int       inv_ph;   // 0 idle, 1 collecting acks, 2 waiting for L2 to drop
    bit [1:0] owe;      // L1s that still owe an ack
    bit       ack_q;
    bit [1:0] g_prev;   // grant each requester saw in the cycle just ended

    initial begin
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) begin
                owner = -1; own_we = 0; last = 1;
                inv_ph = 0; owe = 2'b11; ack_q = 0; g_prev = 0;
            end else begin
                g_prev = 0;
                if (owner >= 0) g_prev[owner] = s_gnt_i;
                ack_q = 0;
                if (inv_ph == 0) begin
                    if (s_inv_req_i) begin inv_ph = 1; owe = 2'b11; end
                end else if (inv_ph == 1) begin
                    owe = owe & ~m_inv_ack;
                    if (owe == 0) begin ack_q = 1; inv_ph = 2; end
                end else begin
                    if (!s_inv_req_i) inv_ph = 0;
                end
                if (owner < 0) begin
                    if (m_req != 0) begin
                        int pref;
                        pref = FIXED ? 1 : 1 - last;
                        owner = m_req[pref] ? pref : 1 - pref;
                        own_we = m_we[owner];
                    end
                end else if (own_we ? s_gnt_i : s_rvalid_i) begin
                    last = owner;
                    owner = -1;
                end
            end
        end
    end

    // Compare every output against the model in the middle of each cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && cmp_en) begin
                logic          e_req, e_we;
                logic [BW-1:0] e_be;
                logic [AW-1:0] e_addr;
                logic [DW-1:0] e_wd;
                logic [1:0]    e_gnt, e_rv, e_ir;
                e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wd = 0;
                e_gnt = 0; e_rv = 0; e_ir = 0;
                if (owner >= 0) begin
                    e_req = m_req[owner];
                    e_we = m_we[owner];
                    e_be = m_be[owner];
                    e_addr = m_addr[owner];
                    e_wd = m_wdata[owner];
                    e_gnt[owner] = s_gnt_i;
                    e_rv[owner] = s_rvalid_i;
                end
                if (inv_ph == 1 && s_inv_req_i) e_ir = owe;
                chk("s_req", s_req_o, e_req);
                chk("s_we", s_we_o, e_we);
                chk("s_be", s_be_o, e_be);
                chk("s_addr", s_addr_o, e_addr);
                chk("s_wdata", s_wdata_o, e_wd);
                chk("gnt", m_gnt, e_gnt);
                chk("rvalid", m_rvalid, e_rv);
                chk("rdata0", m_rdata[0], s_rdata_i);
                chk("rdata1", m_rdata[1], s_rdata_i);
                chk("inv_req", m_inv_req, e_ir);
                chk("inv_addr0", m_inv_addr[0], s_inv_addr_i);
                chk("inv_addr1", m_inv_addr[1], s_inv_addr_i);
                chk("inv_ack", s_inv_ack_o, ack_q);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m_req = 0; m_we = 0; m_be = 0; m_addr = 0; m_wdata = 0; m_inv_ack = 0;
        s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 0;
        s_inv_req_i = 0; s_inv_addr_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0;
        clear_inputs();
        step();
        step();
        rst_ni = 1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_req"}, s_req_o, 0);
        chk({tag, "_s_addr"}, s_addr_o, 0);
        chk({tag, "_s_be"}, s_be_o, 0);
        chk({tag, "_gnt"}, m_gnt, 0);
        chk({tag, "_rvalid"}, m_rvalid, 0);
        chk({tag, "_inv_req"}, m_inv_req, 0);
        chk({tag, "_inv_ack"}, s_inv_ack_o, 0);
    endtask

    // Both request together; 'first' must be served, then the other.
    task automatic both_round(input int first);
        int oth;
        oth = 1 - first;
        m_req = 2'b11; m_we = 0;
        m_addr[0] = 64'h100; m_addr[1] = 64'h200;
        step();
        s_gnt_i = 1; s_rvalid_i = 1;
        @(negedge clk_i);
        chk("rr_first_addr", s_addr_o, first ? 64'h200 : 64'h100);
        chk("rr_first_rv", m_rvalid, first ? 2'b10 : 2'b01);
        step();
        m_req[first] = 0; s_gnt_i = 0; s_rvalid_i = 0;
        @(negedge clk_i);
        chk("rr_gap_req", s_req_o, 0);
        step();
        s_gnt_i = 1; s_rvalid_i = 1;
        @(negedge clk_i);
        chk("rr_second_addr", s_addr_o, oth ? 64'h200 : 64'h100);
        step();
        m_req = 0; s_gnt_i = 0; s_rvalid_i = 0;
    endtask

    initial begin
        clear_inputs();
        step();
        step();
        chk_zero("rst");
        rst_ni = 1;
        cmp_en = 1;

        // lone m0 read, L2 hit
        m_req[0] = 1; m_addr[0] = 64'h1000;
        @(negedge clk_i);
        chk("t1_c0_req", s_req_o, 0);
        step();
        s_gnt_i = 1; s_rvalid_i = 1; s_rdata_i = 64'hA5;
        @(negedge clk_i);
        chk("t1_c1_req", s_req_o, 1);
        chk("t1_addr", s_addr_o, 64'h1000);
        chk("t1_rv", m_rvalid, 2'b01);
        chk("t1_rdata", m_rdata[0], 64'hA5);
        chk("t1_m1_gnt", m_gnt[1], 0);
        step();
        m_req = 0; s_gnt_i = 0; s_rvalid_i = 0;
        @(negedge clk_i);
        chk("t1_idle_req", s_req_o, 0);

        // after m0 served, a tie goes to m1
        both_round(1);
        // after reset, a tie goes to m0 (m1 with fixed priority)
        do_reset();
        both_round(FIXED ? 1 : 0);

        // m1 write completes on gnt, pending m0 follows
        m_req[1] = 1; m_we[1] = 1; m_be[1] = 8'h0F;
        m_addr[1] = 64'h3000; m_wdata[1] = 64'hDEAD;
        step();
        m_req[0] = 1; m_addr[0] = 64'h3100; s_gnt_i = 1;
        @(negedge clk_i);
        chk("t3_we", s_we_o, 1);
        chk("t3_be", s_be_o, 8'h0F);
        chk("t3_wdata", s_wdata_o, 64'hDEAD);
        chk("t3_gnt", m_gnt, 2'b10);
        step();
        m_req[1] = 0; m_we[1] = 0; s_gnt_i = 0;
        step();
        s_gnt_i = 1; s_rvalid_i = 1;
        @(negedge clk_i);
        chk("t3_m0_addr", s_addr_o, 64'h3100);
        chk("t3_m0_rv", m_rvalid, 2'b01);
        step();
        m_req = 0; s_gnt_i = 0; s_rvalid_i = 0;

        // m0 read miss: rvalid after 20 cycles without gnt
        m_req[0] = 1; m_addr[0] = 64'h5000;
        step();
        m_req[1] = 1; m_addr[1] = 64'h5100;
        for (int i = 0; i < 20; i++) begin
            m_req[0] = (i < 10);
            @(negedge clk_i);
            chk("t4_m1_gnt", m_gnt[1], 0);
            chk("t4_follow", s_req_o, (i < 10));
            step();
        end
        s_rvalid_i = 1;
        @(negedge clk_i);
        chk("t4_rv", m_rvalid, 2'b01);
        step();
        s_rvalid_i = 0;
        step();
        s_gnt_i = 1; s_rvalid_i = 1;
        @(negedge clk_i);
        chk("t4_m1_addr", s_addr_o, 64'h5100);
        step();
        m_req = 0; s_gnt_i = 0; s_rvalid_i = 0;

        // back-invalidate, staggered acks
        s_inv_req_i = 1; s_inv_addr_i = 64'h4000;
        @(negedge clk_i);
        chk("t5_c0_ir", m_inv_req, 2'b00);
        step();
        @(negedge clk_i);
        chk("t5_c1_ir", m_inv_req, 2'b11);
        chk("t5_addr", m_inv_addr[1], 64'h4000);
        step();
        m_inv_ack[0] = 1;
        step();
        m_inv_ack[0] = 0;
        @(negedge clk_i);
        chk("t5_c3_ir", m_inv_req, 2'b10);
        step();
        step();
        m_inv_ack[1] = 1;
        @(negedge clk_i);
        chk("t5_c5_ack", s_inv_ack_o, 0);
        step();
        m_inv_ack[1] = 0;
        @(negedge clk_i);
        chk("t5_c6_ack", s_inv_ack_o, 1);
        chk("t5_c6_ir", m_inv_req, 2'b00);
        step();
        s_inv_req_i = 0;
        @(negedge clk_i);
        chk("t5_c7_ack", s_inv_ack_o, 0);
        step();
        // simultaneous acks
        s_inv_req_i = 1;
        step();
        m_inv_ack = 2'b11;
        step();
        m_inv_ack = 0;
        @(negedge clk_i);
        chk("t5b_ack", s_inv_ack_o, 1);
        step();
        s_inv_req_i = 0;
        @(negedge clk_i);
        chk("t5b_ack_end", s_inv_ack_o, 0);
        step();

        // asynchronous reset with a transaction and an invalidate open
        m_req[0] = 1; m_addr[0] = 64'h6000; s_inv_req_i = 1;
        step();
        @(negedge clk_i);
        chk("t6_pre_req", s_req_o, 1);
        #1;
        rst_ni = 0;
        #1;
        chk_zero("t6");
        s_gnt_i = 1; s_rvalid_i = 1;
        #1;
        chk("t6_late_rv", m_rvalid, 0);
        step();
        step();
        m_req = 0; s_inv_req_i = 0; s_gnt_i = 0;
        rst_ni = 1;
        #2;
        chk("t6_after_rv", m_rvalid, 0);
        step();
        s_rvalid_i = 0;

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int n = 0; n < 2; n++) begin
                if (m_req[n] && g_prev[n]) begin
                    m_req[n] = 0;
                end else if (!m_req[n] && $urandom_range(3) == 0) begin
                    m_req[n] = 1;
                    m_we[n] = 1'($urandom_range(1));
                    m_be[n] = 8'($urandom);
                    m_addr[n] = {$urandom, $urandom};
                    m_wdata[n] = {$urandom, $urandom};
                end
                m_inv_ack[n] = ($urandom_range(3) == 0);
            end
            s_gnt_i = ($urandom_range(2) == 0);
            s_rvalid_i = ($urandom_range(2) == 0);
            s_rdata_i = {$urandom, $urandom};
            if (!s_inv_req_i) begin
                if ($urandom_range(7) == 0) begin
                    s_inv_req_i = 1;
                    s_inv_addr_i = {$urandom, $urandom};
                end
            end else if (inv_ph == 2 && $urandom_range(1) == 1) begin
                s_inv_req_i = 0;
            end
        end
        step();
        cmp_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
